// File: rtl/xyolo_pipe_if.sv
// Stream bundle between the Versat read engines, xyolo_pipe and the write-back engine.
// The master side drives beats and configuration; the slave side returns results and busy.
interface xyolo_pipe_if #(
    parameter int DATA_W  = 32,
    parameter int N_MACS  = 4,
    parameter int SHIFT_W = 6,
    parameter int MP_W    = 3
);
    localparam int SEL_W = (N_MACS > 1) ? $clog2(N_MACS) : 1;

    logic                     in_valid;
    logic                     acc_first;
    logic                     acc_last;
    logic [N_MACS*DATA_W-1:0] in_pixel;
    logic [N_MACS*DATA_W-1:0] in_weight;
    logic [DATA_W-1:0]        in_bias;
    logic                     cfg_bias;
    logic [1:0]               cfg_act;
    logic [SHIFT_W-1:0]       cfg_shift;
    logic [MP_W-1:0]          cfg_mp_len;
    logic                     cfg_bypass;
    logic [SEL_W-1:0]         cfg_sel;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic                     busy;

    modport master (
        output in_valid, acc_first, acc_last, in_pixel, in_weight, in_bias,
               cfg_bias, cfg_act, cfg_shift, cfg_mp_len, cfg_bypass, cfg_sel,
        input  out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, acc_first, acc_last, in_pixel, in_weight, in_bias,
               cfg_bias, cfg_act, cfg_shift, cfg_mp_len, cfg_bypass, cfg_sel,
        output out_valid, out_data, busy
    );
endinterface

// File: rtl/xyolo_pipe.sv
// YOLO convolution datapath: lane multiply, registered adder tree, windowed accumulate
// with optional bias, saturating rescale, activation and max-pool output stage.
// Every beat that ends a result takes the same L+5 cycle path, bypass included.
module xyolo_pipe #(
    parameter int DATA_W  = 32,
    parameter int N_MACS  = 4,
    parameter int FRAC_W  = 8,
    parameter int SHIFT_W = 6,
    parameter int MP_W    = 3
) (
    input logic        clk,
    input logic        rst,
    xyolo_pipe_if.slave bus
);
    localparam int L     = (N_MACS > 1) ? $clog2(N_MACS) : 0;
    localparam int W2    = 2 * DATA_W;
    localparam int NODES = 2 * N_MACS - 1;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] K_ONE   = DATA_W'(1)  << FRAC_W;
    localparam logic signed [DATA_W-1:0] K_FIVE  = DATA_W'(5)  << FRAC_W;
    localparam logic signed [DATA_W-1:0] K_T2    = DATA_W'(19) << (FRAC_W - 3);
    localparam logic signed [DATA_W-1:0] K_C84   = DATA_W'(27) << (FRAC_W - 5);
    localparam logic signed [DATA_W-1:0] K_C62   = DATA_W'(5)  << (FRAC_W - 3);
    localparam logic signed [DATA_W-1:0] K_HALF  = DATA_W'(1)  << (FRAC_W - 1);

    function automatic logic [W2-1:0] sext2(input logic [DATA_W-1:0] x);
        return {{DATA_W{x[DATA_W-1]}}, x};
    endfunction

    logic [SHIFT_W-1:0] shift_amt;
    assign shift_amt = bus.cfg_shift;

    // Tree is a heap: node i sums children 2i+1 and 2i+2; leaves N_MACS-1.. hold products.
    logic [W2-1:0]     prod      [N_MACS];
    logic [DATA_W-1:0] byp_sel;
    logic [W2-1:0]     tree      [NODES];
    logic              v_pipe    [L+1];
    logic              first_pipe[L+1];
    logic              last_pipe [L+1];
    logic [DATA_W-1:0] pix_pipe  [L+1];
    logic [DATA_W-1:0] bias_pipe [L+1];

    // Lane products plus the bypass lane pick; out-of-range selects fall back to lane 0
    always_comb begin
        byp_sel = bus.in_pixel[DATA_W-1:0];
        for (int k = 0; k < N_MACS; k++) begin
            prod[k] = sext2(bus.in_pixel[k*DATA_W +: DATA_W]) * sext2(bus.in_weight[k*DATA_W +: DATA_W]);
            if (int'(bus.cfg_sel) == k) byp_sel = bus.in_pixel[k*DATA_W +: DATA_W];
        end
    end

    // Product registers, adder tree levels and the tags that ride alongside them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NODES; i++) tree[i] <= '0;
            for (int i = 0; i <= L; i++) begin
                v_pipe[i]     <= 1'b0;
                first_pipe[i] <= 1'b0;
                last_pipe[i]  <= 1'b0;
                pix_pipe[i]   <= '0;
                bias_pipe[i]  <= '0;
            end
        end else begin
            for (int k = 0; k < N_MACS; k++) tree[N_MACS-1+k] <= prod[k];
            for (int i = 0; i < N_MACS - 1; i++) tree[i] <= tree[2*i+1] + tree[2*i+2];
            v_pipe[0]     <= bus.in_valid;
            first_pipe[0] <= bus.acc_first;
            last_pipe[0]  <= bus.acc_last;
            pix_pipe[0]   <= byp_sel;
            bias_pipe[0]  <= bus.in_bias;
            for (int i = 1; i <= L; i++) begin
                v_pipe[i]     <= v_pipe[i-1];
                first_pipe[i] <= first_pipe[i-1];
                last_pipe[i]  <= last_pipe[i-1];
                pix_pipe[i]   <= pix_pipe[i-1];
                bias_pipe[i]  <= bias_pipe[i-1];
            end
        end
    end

    logic [W2-1:0]     acc;
    logic [W2-1:0]     bias_term;
    logic              a_valid;
    logic              a_byp;
    logic [DATA_W-1:0] a_pix;

    // Bias is pre-shifted so it survives the rescale at the same weight as the products
    assign bias_term = bus.cfg_bias ? (sext2(bias_pipe[L]) << shift_amt) : '0;

    // Accumulate windows; only last beats (or any bypass beat) become results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            a_valid <= 1'b0;
            a_byp   <= 1'b0;
            a_pix   <= '0;
        end else begin
            a_valid <= 1'b0;
            if (v_pipe[L]) begin
                if (bus.cfg_bypass) begin
                    a_valid <= 1'b1;
                    a_byp   <= 1'b1;
                    a_pix   <= pix_pipe[L];
                end else begin
                    acc     <= (first_pipe[L] ? bias_term : acc) + tree[0];
                    a_valid <= last_pipe[L];
                    a_byp   <= 1'b0;
                end
            end
        end
    end

    logic signed [W2-1:0] acc_shr;
    logic [DATA_W-1:0]    sat_y;

    // Arithmetic rescale, clamped when the upper bits are not a pure sign extension
    always_comb begin
        acc_shr = $signed(acc) >>> shift_amt;
        if (&acc_shr[W2-1:DATA_W-1] || ~|acc_shr[W2-1:DATA_W-1]) sat_y = acc_shr[DATA_W-1:0];
        else if (acc_shr[W2-1])                                   sat_y = SAT_MIN;
        else                                                      sat_y = SAT_MAX;
    end

    logic              s_valid;
    logic              s_byp;
    logic [DATA_W-1:0] s_data;

    // Rescale stage register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid <= 1'b0;
            s_byp   <= 1'b0;
            s_data  <= '0;
        end else begin
            s_valid <= a_valid;
            if (a_valid) begin
                s_byp  <= a_byp;
                s_data <= a_byp ? a_pix : sat_y;
            end
        end
    end

    logic signed [DATA_W-1:0] y, abs_y, sig_s, act_y;

    // Activation functions; sigmoid is a piecewise-linear fit mirrored for negatives
    always_comb begin
        y = s_data;
        if (!y[DATA_W-1])   abs_y = y;
        else if (y == SAT_MIN) abs_y = SAT_MAX;
        else                abs_y = -y;
        if (abs_y >= K_FIVE)     sig_s = K_ONE;
        else if (abs_y >= K_T2)  sig_s = K_C84 + (abs_y >>> 5);
        else if (abs_y >= K_ONE) sig_s = K_C62 + (abs_y >>> 3);
        else                     sig_s = K_HALF + (abs_y >>> 2);
        act_y = y;
        case (bus.cfg_act)
            2'd1:    if (y[DATA_W-1]) act_y = y >>> 3;
            2'd2:    act_y = y[DATA_W-1] ? (K_ONE - sig_s) : sig_s;
            2'd3:    if (y[DATA_W-1]) act_y = '0;
            default: act_y = y;
        endcase
    end

    logic                     f_valid;
    logic signed [DATA_W-1:0] f_data;

    // Activation stage register; bypass data passes untouched
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_valid <= 1'b0;
            f_data  <= '0;
        end else begin
            f_valid <= s_valid;
            if (s_valid) f_data <= s_byp ? $signed(s_data) : act_y;
        end
    end

    logic [MP_W-1:0]          pool_n;
    logic [MP_W-1:0]          p_cnt;
    logic signed [DATA_W-1:0] p_max;
    logic signed [DATA_W-1:0] p_cur;
    logic                     out_valid_r;
    logic [DATA_W-1:0]        out_data_r;
    logic                     busy_c;

    // Running max including the incoming result; first result of a window starts fresh
    always_comb begin
        pool_n = (bus.cfg_mp_len == '0) ? MP_W'(1) : bus.cfg_mp_len;
        p_cur  = f_data;
        if (p_cnt != '0 && p_max > f_data) p_cur = p_max;
    end

    // Max-pool counter and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_cnt       <= '0;
            p_max       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            out_valid_r <= 1'b0;
            if (f_valid) begin
                if ((MP_W+1)'(p_cnt) + (MP_W+1)'(1) == (MP_W+1)'(pool_n)) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= p_cur;
                    p_cnt       <= '0;
                end else begin
                    p_max <= p_cur;
                    p_cnt <= p_cnt + MP_W'(1);
                end
            end
        end
    end

    // Busy while any valid is in the pipe or a pool window is partially filled
    always_comb begin
        busy_c = a_valid | s_valid | f_valid | (p_cnt != '0);
        for (int i = 0; i <= L; i++) busy_c = busy_c | v_pipe[i];
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.busy      = busy_c;
endmodule

// File: tb/tb_xyolo_pipe.sv
// Directed bench for xyolo_pipe: a vector table of single-beat windows plus
// hand-written bypass/pool, bubble and mid-window reset sequences.
module tb_xyolo_pipe;
    localparam int LAT = 7;

    typedef struct {
        string       name;
        logic [127:0] pix;
        logic [127:0] wt;
        logic [31:0]  bias;
        logic         cbias;
        logic [1:0]   act;
        logic [5:0]   shift;
        logic [31:0]  expv;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    vec_t vecs[$];
    logic [31:0] pulses[$];

    always #5 clk = ~clk;

    xyolo_pipe_if #(.DATA_W(32), .N_MACS(4), .SHIFT_W(6), .MP_W(3)) bus ();

    xyolo_pipe #(.DATA_W(32), .N_MACS(4), .FRAC_W(8), .SHIFT_W(6), .MP_W(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Record every result pulse for the multi-beat sequences
    always @(negedge clk) if (bus.out_valid === 1'b1) pulses.push_back(bus.out_data);

    // Hard stop in case something wedges the stimulus
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [127:0] pack4(input logic [31:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic add_vec(input string n, input logic [127:0] pix, wt, input logic [31:0] bias,
                           input logic cbias, input logic [1:0] act, input logic [5:0] shift,
                           input logic [31:0] expv);
        vec_t v;
        v.name = n; v.pix = pix; v.wt = wt; v.bias = bias;
        v.cbias = cbias; v.act = act; v.shift = shift; v.expv = expv;
        vecs.push_back(v);
    endtask

    // Drive one beat at the current negedge, release it at the next one
    task automatic apply_stimulus(input logic [127:0] pix, wt, input logic [31:0] bias,
                                  input logic first, last);
        bus.in_valid  = 1'b1;
        bus.in_pixel  = pix;
        bus.in_weight = wt;
        bus.in_bias   = bias;
        bus.acc_first = first;
        bus.acc_last  = last;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.acc_first = 1'b0;
        bus.acc_last  = 1'b0;
    endtask

    // Called one negedge after the final beat; checks pulse cycle and value
    task automatic wait_result(input string name, input logic [31:0] expv);
        int seen;
        logic [31:0] got;
        seen = 0;
        got  = 32'hDEAD_BEEF;
        for (int c = 1; c <= 12; c++) begin
            if (bus.out_valid === 1'b1 && seen == 0) begin
                seen = c;
                got  = bus.out_data;
            end
            @(negedge clk);
        end
        check_output({name, "_lat"}, 32'(seen), 32'(LAT));
        check_output({name, "_data"}, got, expv);
    endtask

    task automatic run_vector(input vec_t v);
        bus.cfg_bias   = v.cbias;
        bus.cfg_act    = v.act;
        bus.cfg_shift  = v.shift;
        bus.cfg_mp_len = 3'd1;
        bus.cfg_bypass = 1'b0;
        bus.cfg_sel    = 2'd0;
        apply_stimulus(v.pix, v.wt, v.bias, 1'b1, 1'b1);
        wait_result(v.name, v.expv);
    endtask

    initial begin
        logic [31:0] lane2[8];
        logic [31:0] p0, p1;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.acc_first = 1'b0; bus.acc_last = 1'b0;
        bus.in_pixel = '0; bus.in_weight = '0; bus.in_bias = '0;
        bus.cfg_bias = 1'b0; bus.cfg_act = 2'd0; bus.cfg_shift = '0;
        bus.cfg_mp_len = '0; bus.cfg_bypass = 1'b0; bus.cfg_sel = '0;

        add_vec("basic",     pack4(32'h100, 32'h100, 32'h100, 32'h100), pack4(32'h100, 32'h200, 32'h300, 32'h400), 32'h80, 1'b1, 2'd0, 6'd8, 32'h0000_0A80);
        add_vec("lanes_bias",pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 32'h10, 1'b1, 2'd0, 6'd0, 32'h0000_0056);
        add_vec("lanes_nob", pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 32'h10, 1'b0, 2'd0, 6'd0, 32'h0000_0046);
        add_vec("shift_neg", pack4(32'hFFFF_FD00, 0, 0, 0), pack4(1, 0, 0, 0), 32'h0, 1'b0, 2'd0, 6'd4, 32'hFFFF_FFD0);
        add_vec("leaky_neg", pack4(32'hFFFF_F800, 0, 0, 0), pack4(1, 0, 0, 0), 32'h0, 1'b0, 2'd1, 6'd0, 32'hFFFF_FF00);
        add_vec("relu_neg",  pack4(32'hFFFF_F800, 0, 0, 0), pack4(1, 0, 0, 0), 32'h0, 1'b0, 2'd3, 6'd0, 32'h0000_0000);
        add_vec("leaky_pos", pack4(32'h300, 0, 0, 0), pack4(1, 0, 0, 0), 32'h0, 1'b0, 2'd1, 6'd0, 32'h0000_0300);
        add_vec("relu_pos",  pack4(32'h300, 0, 0, 0), pack4(1, 0, 0, 0), 32'h0, 1'b0, 2'd3, 6'd0, 32'h0000_0300);
        add_vec("sig_p180",  pack4(32'h180, 0, 0, 0), pack4(1, 0, 0, 0), 32'h0, 1'b0, 2'd2, 6'd0, 32'h0000_00D0);
        add_vec("sig_m180",  pack4(32'hFFFF_FE80, 0, 0, 0), pack4(1, 0, 0, 0), 32'h0, 1'b0, 2'd2, 6'd0, 32'h0000_0030);
        add_vec("sig_600",   pack4(32'h600, 0, 0, 0), pack4(1, 0, 0, 0), 32'h0, 1'b0, 2'd2, 6'd0, 32'h0000_0100);
        add_vec("sig_40",    pack4(32'h40, 0, 0, 0), pack4(1, 0, 0, 0), 32'h0, 1'b0, 2'd2, 6'd0, 32'h0000_0090);
        add_vec("sat_pos",   pack4(32'h1_0000, 0, 0, 0), pack4(32'h1_0000, 0, 0, 0), 32'h0, 1'b0, 2'd0, 6'd0, 32'h7FFF_FFFF);
        add_vec("sat_neg",   pack4(32'hFFFF_0000, 0, 0, 0), pack4(32'h1_0000, 0, 0, 0), 32'h0, 1'b0, 2'd0, 6'd0, 32'h8000_0000);

        $display("[TB] reset phase");
        @(negedge clk);
        @(negedge clk);
        check_output("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check_output("rst_out_data", bus.out_data, 32'h0);
        check_output("rst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] vector table");
        foreach (vecs[i]) run_vector(vecs[i]);

        $display("[TB] bypass with 4-deep pooling");
        lane2 = '{32'd5, 32'hFFFF_FFFD, 32'd9, 32'd7, 32'd1, 32'd1, 32'd1, 32'd2};
        bus.cfg_bypass = 1'b1; bus.cfg_sel = 2'd2; bus.cfg_mp_len = 3'd4;
        bus.cfg_act = 2'd3; bus.cfg_shift = 6'd5;
        pulses.delete();
        for (int i = 0; i < 8; i++)
            apply_stimulus(pack4(32'h77, 32'h66, lane2[i], 32'h55), pack4(32'h3, 32'h4, 32'h5, 32'h6), 32'h0, 1'b0, 1'b0);
        check_output("byp_busy_mid", 32'(bus.busy), 32'h1);
        for (int c = 0; c < 10; c++) @(negedge clk);
        p0 = (pulses.size() > 0) ? pulses[0] : 32'hDEAD_BEEF;
        p1 = (pulses.size() > 1) ? pulses[1] : 32'hDEAD_BEEF;
        check_output("byp_pulse_count", 32'(pulses.size()), 32'd2);
        check_output("byp_pool0", p0, 32'd9);
        check_output("byp_pool1", p1, 32'd2);
        check_output("byp_busy_end", 32'(bus.busy), 32'h0);
        check_output("byp_hold", bus.out_data, 32'd2);

        $display("[TB] three-beat window with bubbles");
        bus.cfg_bypass = 1'b0; bus.cfg_sel = 2'd0; bus.cfg_mp_len = 3'd0;
        bus.cfg_act = 2'd0; bus.cfg_shift = 6'd0; bus.cfg_bias = 1'b0;
        pulses.delete();
        apply_stimulus(pack4(32'h10, 0, 0, 0), pack4(32'h10, 0, 0, 0), 32'h999, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        apply_stimulus(pack4(0, 32'h8, 0, 0), pack4(0, 32'h20, 0, 0), 32'h999, 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(pack4(0, 0, 0, 32'h4), pack4(0, 0, 0, 32'h40), 32'h999, 1'b0, 1'b1);
        wait_result("bubbles", 32'h300);
        check_output("bubbles_count", 32'(pulses.size()), 32'd1);

        $display("[TB] reset in the middle of a window");
        pulses.delete();
        apply_stimulus(pack4(32'h10, 0, 0, 0), pack4(32'h10, 0, 0, 0), 32'h0, 1'b1, 1'b0);
        apply_stimulus(pack4(32'h10, 0, 0, 0), pack4(32'h10, 0, 0, 0), 32'h0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("midrst_out_data", bus.out_data, 32'h0);
        check_output("midrst_busy", 32'(bus.busy), 32'h0);
        for (int c = 0; c < 12; c++) @(negedge clk);
        check_output("midrst_no_pulse", 32'(pulses.size()), 32'd0);
        apply_stimulus(pack4(32'h10, 0, 0, 0), pack4(32'h10, 0, 0, 0), 32'h0, 1'b1, 1'b0);
        apply_stimulus(pack4(32'h20, 0, 0, 0), pack4(32'h10, 0, 0, 0), 32'h0, 1'b0, 1'b1);
        wait_result("after_rst", 32'h300);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
